// File: rtl/dcp_transmittance_dark_if.sv
`default_nettype none
// ============================================================================
// Module   : dcp_transmittance_dark_if
// Purpose  : Pixel-stream bundle between the dark-channel min-filter, the
//            transmission-map stage and the haze-free recovery stage.
// Signals  : i_dark[7:0]          dark-channel pixel into the stage
//            i_data_valid         qualifies i_dark
//            o_dark_max[7:0]      atmospheric-light estimate A
//            o_transmittance[7:0] transmittance, 255 = 1.0
//            o_data_valid         qualifies o_transmittance
// Modports : slave  - the transmittance stage itself
//            master - the producer/consumer side around it
// Revision : 1.0 - initial release
// ============================================================================
interface dcp_transmittance_dark_if;
  logic [7:0] i_dark;
  logic       i_data_valid;
  logic [7:0] o_dark_max;
  logic [7:0] o_transmittance;
  logic       o_data_valid;

  modport slave (
    input  i_dark,
    input  i_data_valid,
    output o_dark_max,
    output o_transmittance,
    output o_data_valid
  );

  modport master (
    output i_dark,
    output i_data_valid,
    input  o_dark_max,
    input  o_transmittance,
    input  o_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/dcp_transmittance_dark.sv
`default_nettype none
// ============================================================================
// Module   : dcp_transmittance_dark
// Purpose  : Transmission-map stage of the DCP dehaze pipeline. Tracks the
//            atmospheric light A (running max of valid dark pixels) and emits
//            t = 255 - ((floor(dark*255/A) * 243) >> 8), floored at T0.
//            12-cycle fixed latency, one pixel per cycle, no back-pressure.
// Ports    : pixelclk - pixel clock, rising edge
//            reset_n  - asynchronous active-low reset
//            bus      - slave side of dcp_transmittance_dark_if
// Params   : T0       - lower clamp of the output transmittance
// Revision : 1.0 - initial release
// ============================================================================
module dcp_transmittance_dark #(
  parameter logic [7:0] T0 = 8'd26
) (
  input logic                     pixelclk,
  input logic                     reset_n,
  dcp_transmittance_dark_if.slave bus
);

  localparam int c_DIV_STAGES = 8;
  localparam int c_LATENCY    = 12;

  // S1
  logic [7:0]  r_d1;
  logic [7:0]  r_amax;         // serves as both a1 and the held A estimate
  logic [7:0]  w_amax_nxt;
  // S2 .. S10: remainder/divisor carried through the divider, quotient built
  logic [15:0] r_rem [0:c_DIV_STAGES-1];
  logic [7:0]  r_a   [0:c_DIV_STAGES-1];
  logic [7:0]  r_q   [1:c_DIV_STAGES];
  logic [15:0] w_dsr [0:c_DIV_STAGES-1];
  logic [c_DIV_STAGES-1:0] w_ge;
  // S11 / S12
  logic [7:0]  r_w;
  logic [7:0]  r_t;
  logic [7:0]  w_t_raw;
  logic [c_LATENCY-1:0] r_vld;

  // The current pixel participates in its own A, so d1 <= a1 for valid data
  // and the quotient always fits in 8 bits.
  assign w_amax_nxt = (bus.i_data_valid && (bus.i_dark > r_amax)) ? bus.i_dark : r_amax;

  // Restoring divider: stage s decides quotient bit (7-s) by trial-subtracting
  // the divisor aligned to that bit. A zero divisor never sets a bit, which
  // yields the forced q = 0.
  for (genvar s = 0; s < c_DIV_STAGES; s++) begin : g_div
    assign w_dsr[s] = {8'd0, r_a[s]} << (c_DIV_STAGES - 1 - s);
    assign w_ge[s]  = (r_a[s] != 8'd0) && (r_rem[s] >= w_dsr[s]);
  end

  assign w_t_raw = 8'd255 - r_w;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_d1   <= '0;
      r_amax <= '0;
      for (int s = 0; s < c_DIV_STAGES; s++) begin
        r_rem[s]   <= '0;
        r_a[s]     <= '0;
        r_q[s + 1] <= '0;
      end
      r_w   <= '0;
      r_t   <= '0;
      r_vld <= '0;
    end else begin
      // S1
      r_d1   <= bus.i_dark;
      r_amax <= w_amax_nxt;
      // S2: d1*255 computed as d1*256 - d1, exact in 16 bits
      r_rem[0] <= {r_d1, 8'd0} - {8'd0, r_d1};
      r_a[0]   <= r_amax;
      // S3 .. S10
      r_q[1] <= {7'd0, w_ge[0]};
      for (int s = 1; s < c_DIV_STAGES; s++) begin
        r_q[s + 1] <= {r_q[s][6:0], w_ge[s]};
      end
      for (int s = 0; s < c_DIV_STAGES - 1; s++) begin
        r_rem[s + 1] <= w_ge[s] ? (r_rem[s] - w_dsr[s]) : r_rem[s];
        r_a[s + 1]   <= r_a[s];
      end
      // S11: omega = 243/256
      r_w <= 8'(({8'd0, r_q[c_DIV_STAGES]} * 16'd243) >> 8);
      // S12
      r_t <= (w_t_raw < T0) ? T0 : w_t_raw;
      // Valid travels with the data through all 12 registers
      r_vld <= {r_vld[c_LATENCY-2:0], bus.i_data_valid};
    end
  end

  assign bus.o_dark_max      = r_amax;
  assign bus.o_transmittance = r_t;
  assign bus.o_data_valid    = r_vld[c_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_dcp_transmittance_dark.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcp_transmittance_dark
// Purpose  : Self-checking bench for dcp_transmittance_dark. Each driven
//            pixel is turned into an expected result by an arithmetic model
//            and queued; the queue is 12 deep so the head lines up with the
//            output observed on the same negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcp_transmittance_dark;

  localparam int c_T0  = 26;
  localparam int c_LAT = 12;

  typedef struct {
    bit         v;
    logic [7:0] t;
    int         hand;   // hand-derived value from the test plan, -1 if none
  } exp_t;

  logic pixelclk;
  logic reset_n;

  dcp_transmittance_dark_if bif ();

  dcp_transmittance_dark #(.T0(8'd26)) u_dut (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .bus      (bif.slave)
  );

  initial pixelclk = 1'b0;
  always #5 pixelclk = ~pixelclk;

  int         errors;
  int         checks;
  int         m_amax;
  logic [7:0] prev_max;
  exp_t       exp_q [$];

  function automatic logic [7:0] ref_t(input int d, input int a);
    int q, w, t;
    q = (a == 0) ? 0 : (d * 255) / a;
    w = (q * 243) / 256;
    t = 255 - w;
    if (t < c_T0) t = c_T0;
    return 8'(t);
  endfunction

  task automatic model_reset();
    exp_t e;
    m_amax   = 0;
    prev_max = 8'd0;
    exp_q.delete();
    e.v = 1'b0; e.t = 8'd0; e.hand = -1;
    for (int i = 0; i < c_LAT; i++) exp_q.push_back(e);
  endtask

  // One clock: check what is visible now, then drive the next sample.
  task automatic step(input bit v, input logic [7:0] d, input int hand);
    exp_t e, x;
    @(negedge pixelclk);
    checks++;
    if (bif.o_dark_max !== 8'(m_amax)) begin
      errors++;
      $display("FAIL dark_max got=%0d exp=%0d t=%0t", bif.o_dark_max, m_amax, $time);
    end
    checks++;
    if (bif.o_dark_max < prev_max) begin
      errors++;
      $display("FAIL dark_max_monotonic got=%0d prev=%0d", bif.o_dark_max, prev_max);
    end
    prev_max = bif.o_dark_max;
    x = exp_q.pop_front();
    checks++;
    if (bif.o_data_valid !== x.v) begin
      errors++;
      $display("FAIL data_valid got=%b exp=%b t=%0t", bif.o_data_valid, x.v, $time);
    end
    if (x.v) begin
      checks++;
      if (bif.o_transmittance !== x.t) begin
        errors++;
        $display("FAIL transmittance got=%0d exp=%0d t=%0t", bif.o_transmittance, x.t, $time);
      end
      checks++;
      if (bif.o_transmittance < 8'(c_T0)) begin
        errors++;
        $display("FAIL t_floor got=%0d min=%0d", bif.o_transmittance, c_T0);
      end
      if (x.hand >= 0) begin
        checks++;
        if (bif.o_transmittance !== 8'(x.hand)) begin
          errors++;
          $display("FAIL t_plan got=%0d exp=%0d", bif.o_transmittance, x.hand);
        end
      end
    end
    bif.i_dark       = d;
    bif.i_data_valid = v;
    if (v && int'(d) > m_amax) m_amax = int'(d);
    e.v    = v;
    e.t    = v ? ref_t(int'(d), m_amax) : 8'd0;
    e.hand = hand;
    exp_q.push_back(e);
  endtask

  task automatic check_max_now(input int want, input string name);
    @(posedge pixelclk);
    #1;
    checks++;
    if (bif.o_dark_max !== 8'(want)) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, bif.o_dark_max, want);
    end
  endtask

  task automatic do_reset(input bit chk);
    @(negedge pixelclk);
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bif.i_dark       = 8'($urandom_range(0, 255));
      bif.i_data_valid = 1'b1;
      @(negedge pixelclk);
      if (chk) begin
        checks++;
        if ({bif.o_dark_max, bif.o_transmittance, bif.o_data_valid} !== 17'd0) begin
          errors++;
          $display("FAIL reset_outputs got max=%0d t=%0d v=%b exp=0",
                   bif.o_dark_max, bif.o_transmittance, bif.o_data_valid);
        end
      end
    end
    bif.i_data_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b1);
  endtask

  task automatic test_zero_clamp();
    step(1'b1, 8'd0, 255);
    check_max_now(0, "max_after_zero");
    step(1'b1, 8'd200, 26);
    check_max_now(200, "max_after_200");
  endtask

  task automatic test_mid_value();
    step(1'b1, 8'd100, 135);
    check_max_now(200, "max_held_200");
  endtask

  task automatic test_max_tracking();
    int vals  [4] = '{50, 30, 240, 10};
    int maxs  [4] = '{50, 50, 240, 240};
    int hands [4] = '{26, 110, 26, 246};
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(vals[i]), hands[i]);
      check_max_now(maxs[i], "max_tracking");
    end
  endtask

  task automatic test_valid_gating();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'd255, -1);
      check_max_now(240, "max_gated");
    end
    step(1'b1, 8'd120, -1);
    for (int i = 0; i < c_LAT; i++) step(1'b0, 8'd255, -1);
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 10000; i++) begin
      if (i % 2000 == 0) do_reset(1'b0);
      step(1'b1, 8'($urandom_range(0, 255)), -1);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), -1);
    @(negedge pixelclk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bif.o_data_valid !== 1'b0 || bif.o_dark_max !== 8'd0 || bif.o_transmittance !== 8'd0) begin
      errors++;
      $display("FAIL midstream_reset got v=%b max=%0d t=%0d exp=0",
               bif.o_data_valid, bif.o_dark_max, bif.o_transmittance);
    end
    repeat (3) @(negedge pixelclk);
    bif.i_data_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
    step(1'b1, 8'd0, 255);
    step(1'b1, 8'd7, 26);
    step(1'b1, 8'd3, -1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bif.i_dark = 8'd0;
    bif.i_data_valid = 1'b0;
    model_reset();

    test_reset();
    test_zero_clamp();
    test_mid_value();
    test_max_tracking();
    test_valid_gating();
    test_random_stream();
    test_reset_midstream();
    for (int i = 0; i < c_LAT + 2; i++) step(1'b0, 8'd0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcp_transmittance_dark.md
# dcp_transmittance_dark

Transmission-map stage of the dark-channel-prior (DCP) dehaze pipeline. It consumes a stream of 8-bit dark-channel pixels and tracks the atmospheric-light estimate A, the running maximum of the dark channel. For each pixel it computes the transmittance t = 1 − ω·dark/A with ω ≈ 0.95, scaled to 0..255 and floored at T0. It sits between the dark-channel min-filter and the haze-free recovery stage.

## Interface
- `T0`, default 8'd26: lower clamp of the output transmittance (≈0.1·255).

- `pixelclk`, input, 1: pixel clock; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `i_dark`, input, 8: dark-channel pixel value.
- `i_data_valid`, input, 1: qualifies `i_dark` in the same cycle.
- `o_dark_max`, output, 8: current atmospheric-light estimate A, the running maximum of valid `i_dark` since reset.
- `o_transmittance`, output, 8: transmittance, where 255 ≙ 1.0.
- `o_data_valid`, output, 1: qualifies `o_transmittance`.

## Operation
- No frame sync. A accumulates from reset and never decreases; only reset clears it.
- The pipeline advances every cycle. There is no back-pressure and no stall.
- A valid bit travels alongside the data.
- Invalid samples still flow through the pipeline but never update A. Their `o_transmittance` is don't-care.

Pipeline stages (S1 registers the input):
- **S1:**
  - d1 ← i_dark.
  - a1 ← max(amax, i_dark) if i_data_valid, else amax.
  - amax ← a1.
  - `o_dark_max` is driven from amax.
  - The current pixel is included in its own A, so d1 ≤ a1 always holds for valid samples.
- **S2:** n ← d1·255 (16-bit unsigned); carry a1 forward.
- **S3–S10:** 8-stage pipelined restoring divider, q = floor(n / a1).
  - One quotient bit per stage, MSB first.
  - q fits in 8 bits because d1 ≤ a1.
  - If a1 = 0, force q = 0.
- **S11:** w ← (q·243) >> 8. This is a 16-bit product and gives ω = 243/256 ≈ 0.949.
- **S12:** t ← 255 − w; if t < T0 then t = T0. Register to `o_transmittance`.

Arithmetic rules:
- All operations are unsigned and truncating (floor).
- No intermediate result overflows its stated width.

## Timing
- Reset (asynchronous, active-low): all pipeline registers, amax, the valid shift chain, `o_dark_max`, `o_transmittance` and `o_data_valid` go to 0.
- Latency from pixel to result: 12 cycles. A sample presented at edge k appears on `o_transmittance` with `o_data_valid`=1 after edge k+11, i.e. it is registered at edge k+11 with S1 counted at edge k.
- `o_data_valid` is `i_data_valid` delayed by exactly 12 registers.
- `o_dark_max` updates 1 cycle after a valid sample exceeding it.
- Throughput: one pixel per cycle, continuous.
- Reset mid-stream: in-flight results are discarded, A restarts at 0 and `o_data_valid` drops immediately.
- Boundary conditions:
  - A = 0 with dark = 0 → t = 255.
  - dark = A → q = 255, w = 242, t = 13, clamped to T0 = 26.
  - dark = 0 → t = 255 for any A.

## Test plan
- **Reset:** hold reset_n=0 for 100 ns with random i_dark → all outputs 0. Release with i_data_valid=1 → `o_data_valid` rises exactly 12 cycles after the first valid sample.
- **Zero / clamp:** first sample i_dark=0 → t=255 and `o_dark_max`=0. Then i_dark=200 → `o_dark_max`=200 next cycle and t=26 (clamped).
- **Mid value:** with A=200 established, i_dark=100 → q=127, w=120, t=135, 12 cycles later.
- **Max tracking:** feed 50, 30, 240, 10 → `o_dark_max` goes 50, 50, 240, 240. The pixel 10 gives q=10, w=9, t=246.
- **Valid gating:** hold i_data_valid=0 while i_dark=255 → `o_dark_max` is unchanged and `o_data_valid` stays low 12 cycles later. Then reassert.
- **Random stream:** 10k random bytes with continuous valid.
  - Check every output against a reference model: running max, floor(d·255/A), (q·243)>>8, clamp T0.
  - Check t ≥ 26 always.
  - Check `o_dark_max` is monotonic non-decreasing.
